adivinhador_auto: RTL and testbench

Automatic guesser for the two-part password game: drives guesses for senha A (4 bits) and senha B (3 bits) into the hint block and reads back its `comp` and `paridade` outputs. It runs a one-guess-per-cycle binary search, first over senha A with `modoB`=0, then over senha B with `modoB`=1. It reports the recovered passwords, the guess count and a done/error status for the HEX displays and LEDs.

---
 rtl/adivinhador_auto.sv | 155 +++++++++++++++
 tb/tb_adivinhador_auto.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adivinhador_auto.sv
// Automatic binary-search guesser for the two-part password game (senha A, then senha B).
// Optional parity cross-check on the final hit is enabled by defining ADIVINHADOR_PARIDADE_EN.
module adivinhador_auto #(
   parameter int WA       = 4,
   parameter int WB       = 3,
   parameter int MAX_TENT = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          iniciar,
   input  logic [1:0]    comp,
   input  logic          paridade,
   output logic [WA-1:0] tentativaA,
   output logic [WB-1:0] tentativaB,
   output logic          modoB,
   output logic          ocupado,
   output logic          concluido,
   output logic          erro,
   output logic [WA-1:0] resultadoA,
   output logic [WB-1:0] resultadoB,
   output logic [3:0]    num_tentativas
);

   typedef enum logic [2:0] {OCIOSO, AVALIA_A, AVALIA_B, FIM, ERRO} estadoT;

   localparam logic [1:0]    C_MENOR = 2'b00;
   localparam logic [1:0]    C_MAIOR = 2'b01;
   localparam logic [1:0]    C_IGUAL = 2'b10;
   localparam logic [1:0]    C_ILEGAL = 2'b11;
   localparam logic [WA:0]   HI_A  = (WA+1)'((1 << WA) - 1);
   localparam logic [WA:0]   HI_B  = (WA+1)'((1 << WB) - 1);
   localparam logic [WA-1:0] TA0   = WA'(((1 << WA) - 1) >> 1);
   localparam logic [WB-1:0] TB0   = WB'(((1 << WB) - 1) >> 1);
   localparam logic [3:0]    LIMITE = 4'(MAX_TENT);

   estadoT        state, stateNxt;
   logic [WA:0]   lo, hi, loNxt, hiNxt;
   logic [WA-1:0] tentANxt, resANxt;
   logic [WB-1:0] tentBNxt, resBNxt;
   logic          modoBNxt;
   logic [3:0]    numNxt, countInc;

   // One search step shared by both phases; lo/hi are one bit wider so g+1 never wraps.
   logic [WA:0]   gCur, loStep, hiStep, sumStep;
   logic [WA-1:0] guessStep;
   logic          stepBad, parityBad;

`ifdef ADIVINHADOR_PARIDADE_EN
   assign parityBad = (^tentativaA) ^ (^tentativaB) ^ paridade;
`else
   logic unusedParidade;
   assign unusedParidade = paridade;
   assign parityBad      = 1'b0;
`endif

   always_comb begin
      gCur     = (state == AVALIA_B) ? (WA+1)'(tentativaB) : (WA+1)'(tentativaA);
      loStep   = lo;
      hiStep   = hi;
      if (comp == C_MENOR) loStep = gCur + (WA+1)'(1);
      if (comp == C_MAIOR) hiStep = gCur - (WA+1)'(1);
      sumStep  = loStep + hiStep;
      guessStep = WA'(sumStep >> 1);
      // g-1 at g=0 would wrap to all ones, so flag it explicitly as an empty range
      stepBad  = (comp == C_ILEGAL) || (comp == C_MAIOR && gCur == '0) || (loStep > hiStep);
      countInc = num_tentativas + 4'd1;
   end

   always_comb begin
      stateNxt = state;
      loNxt    = lo;
      hiNxt    = hi;
      tentANxt = tentativaA;
      tentBNxt = tentativaB;
      modoBNxt = modoB;
      resANxt  = resultadoA;
      resBNxt  = resultadoB;
      numNxt   = num_tentativas;
      case (state)
         OCIOSO, FIM, ERRO: begin
            if (iniciar) begin
               stateNxt = AVALIA_A;
               loNxt    = '0;
               hiNxt    = HI_A;
               tentANxt = TA0;
               tentBNxt = '0;
               modoBNxt = 1'b0;
               resANxt  = '0;
               resBNxt  = '0;
               numNxt   = '0;
            end
         end
         AVALIA_A: begin
            numNxt = countInc;
            if (comp == C_IGUAL) begin
               stateNxt = AVALIA_B;
               resANxt  = tentativaA;
               loNxt    = '0;
               hiNxt    = HI_B;
               tentBNxt = TB0;
               modoBNxt = 1'b1;
            end else if (stepBad || countInc == LIMITE) begin
               stateNxt = ERRO;
            end else begin
               loNxt    = loStep;
               hiNxt    = hiStep;
               tentANxt = guessStep;
            end
         end
         AVALIA_B: begin
            numNxt = countInc;
            if (comp == C_IGUAL) begin
               resBNxt  = tentativaB;
               stateNxt = parityBad ? ERRO : FIM;
            end else if (stepBad || countInc == LIMITE) begin
               stateNxt = ERRO;
            end else begin
               loNxt    = loStep;
               hiNxt    = hiStep;
               tentBNxt = guessStep[WB-1:0];
            end
         end
         default: stateNxt = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= OCIOSO;
         lo             <= '0;
         hi             <= '0;
         tentativaA     <= '0;
         tentativaB     <= '0;
         modoB          <= 1'b0;
         resultadoA     <= '0;
         resultadoB     <= '0;
         num_tentativas <= '0;
      end else begin
         state          <= stateNxt;
         lo             <= loNxt;
         hi             <= hiNxt;
         tentativaA     <= tentANxt;
         tentativaB     <= tentBNxt;
         modoB          <= modoBNxt;
         resultadoA     <= resANxt;
         resultadoB     <= resBNxt;
         num_tentativas <= numNxt;
      end
   end

   assign ocupado   = (state == AVALIA_A) || (state == AVALIA_B);
   assign concluido = (state == FIM);
   assign erro      = (state == ERRO);

endmodule

// File: tb/tb_adivinhador_auto.sv
// Bench for adivinhador_auto: behavioural hint block plus an integer binary-search reference.
module tb_adivinhador_auto;

   localparam int WA = 4;
   localparam int WB = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          iniciar = 1'b0;
   logic [1:0]    comp;
   logic          paridade;
   logic [WA-1:0] tentativaA, resultadoA;
   logic [WB-1:0] tentativaB, resultadoB;
   logic          modoB, ocupado, concluido, erro;
   logic [3:0]    num_tentativas;

   logic [WA-1:0] senhaA = '0;
   logic [WB-1:0] senhaB = '0;
   logic          parInvert = 1'b0;
   int            forceMode = 0;  // 0 honest, 1 always "lower", 2 always illegal
   int            nVec = 0;
   int            nErr = 0;
   int            expQ[$];

   adivinhador_auto #(.WA(WA), .WB(WB), .MAX_TENT(9)) dut (
      .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .comp(comp), .paridade(paridade),
      .tentativaA(tentativaA), .tentativaB(tentativaB), .modoB(modoB),
      .ocupado(ocupado), .concluido(concluido), .erro(erro),
      .resultadoA(resultadoA), .resultadoB(resultadoB), .num_tentativas(num_tentativas)
   );

   always #5 clk = ~clk;

   // Hint block: combinational compare of the current guess against the active password.
   always_comb begin
      int g, s;
      g = modoB ? int'(tentativaB) : int'(tentativaA);
      s = modoB ? int'(senhaB) : int'(senhaA);
      if (forceMode == 1)      comp = 2'b00;
      else if (forceMode == 2) comp = 2'b11;
      else if (g < s)          comp = 2'b00;
      else if (g > s)          comp = 2'b01;
      else                     comp = 2'b10;
      paridade = (^senhaA) ^ (^senhaB) ^ parInvert;
   end

   function automatic void push_search(int senha, int w);
      int lo, hi, g;
      lo = 0;
      hi = (1 << w) - 1;
      while (lo <= hi) begin
         g = (lo + hi) / 2;
         expQ.push_back(g);
         if (g == senha) break;
         if (g < senha) lo = g + 1;
         else hi = g - 1;
      end
   endfunction

   task automatic pulse_start();
      @(negedge clk) iniciar = 1'b1;
      @(negedge clk) iniciar = 1'b0;
   endtask

   task automatic run_search(input int sa, input int sb, input bit parBad, input string nm);
      int na, nb;
      bit expErr;
      expQ.delete();
      push_search(sa, WA);
      na = expQ.size();
      push_search(sb, WB);
      nb = expQ.size() - na;
      senhaA = WA'(sa); senhaB = WB'(sb); parInvert = parBad; forceMode = 0;
`ifdef ADIVINHADOR_PARIDADE_EN
      expErr = parBad;
`else
      expErr = 1'b0;
`endif
      pulse_start();
      for (int i = 0; i < na + nb; i++) begin
         nVec++;
         if (i < na) begin
            if (modoB !== 1'b0 || tentativaA !== WA'(expQ[i]) || ocupado !== 1'b1) begin
               nErr++;
               $display("FAIL %s guessA[%0d]: got %0d modoB=%0b ocupado=%0b, expected %0d modoB=0 ocupado=1",
                        nm, i, tentativaA, modoB, ocupado, expQ[i]);
            end
         end else begin
            if (modoB !== 1'b1 || tentativaB !== WB'(expQ[i]) || ocupado !== 1'b1) begin
               nErr++;
               $display("FAIL %s guessB[%0d]: got %0d modoB=%0b ocupado=%0b, expected %0d modoB=1 ocupado=1",
                        nm, i, tentativaB, modoB, ocupado, expQ[i]);
            end
         end
         @(negedge clk);
      end
      nVec++;
      if (concluido !== !expErr || erro !== expErr || ocupado !== 1'b0) begin
         nErr++;
         $display("FAIL %s status: got concluido=%0b erro=%0b ocupado=%0b, expected concluido=%0b erro=%0b ocupado=0",
                  nm, concluido, erro, ocupado, !expErr, expErr);
      end
      nVec++;
      if (resultadoA !== WA'(sa) || resultadoB !== WB'(sb) || num_tentativas !== 4'(na + nb)) begin
         nErr++;
         $display("FAIL %s results: got A=%0d B=%0d n=%0d, expected A=%0d B=%0d n=%0d",
                  nm, resultadoA, resultadoB, num_tentativas, sa, sb, na + nb);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iniciar = 1'b0;
      #3;
      nVec++;
      if ({tentativaA, tentativaB, modoB, ocupado, concluido, erro, resultadoA, resultadoB, num_tentativas} !== '0) begin
         nErr++;
         $display("FAIL reset outputs: got A=%0d B=%0d modoB=%0b oc=%0b co=%0b er=%0b n=%0d, expected all 0",
                  tentativaA, tentativaB, modoB, ocupado, concluido, erro, num_tentativas);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      nVec++;
      if (ocupado !== 1'b0 || concluido !== 1'b0 || erro !== 1'b0) begin
         nErr++;
         $display("FAIL reset idle: got oc=%0b co=%0b er=%0b, expected 0 0 0", ocupado, concluido, erro);
      end
   endtask

   task automatic test_basic();
      run_search(11, 5, 1'b0, "basic");
   endtask

   task automatic test_hold();
      repeat (3) @(negedge clk);
      nVec++;
      if (concluido !== 1'b1 || resultadoA !== 4'd11 || resultadoB !== 3'd5 || num_tentativas !== 4'd4
          || tentativaB !== 3'd5 || modoB !== 1'b1) begin
         nErr++;
         $display("FAIL hold: got co=%0b A=%0d B=%0d n=%0d tB=%0d modoB=%0b, expected 1 11 5 4 5 1",
                  concluido, resultadoA, resultadoB, num_tentativas, tentativaB, modoB);
      end
   endtask

   task automatic test_worst();
      run_search(15, 7, 1'b0, "worst");
   endtask

   task automatic test_low();
      run_search(0, 0, 1'b0, "low");
   endtask

   task automatic test_inconsistent();
      int seq[5] = '{7, 11, 13, 14, 15};
      senhaA = 4'd3; forceMode = 1;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         nVec++;
         if (tentativaA !== WA'(seq[i]) || erro !== 1'b0) begin
            nErr++;
            $display("FAIL incons guess[%0d]: got %0d erro=%0b, expected %0d erro=0", i, tentativaA, erro, seq[i]);
         end
         @(negedge clk);
      end
      nVec++;
      if (erro !== 1'b1 || concluido !== 1'b0 || num_tentativas !== 4'd5) begin
         nErr++;
         $display("FAIL incons end: got erro=%0b co=%0b n=%0d, expected 1 0 5", erro, concluido, num_tentativas);
      end
      @(negedge clk);
      nVec++;
      if (erro !== 1'b1 || num_tentativas !== 4'd5) begin
         nErr++;
         $display("FAIL incons hold: got erro=%0b n=%0d, expected 1 5", erro, num_tentativas);
      end
      forceMode = 0;
   endtask

   task automatic test_illegal();
      forceMode = 2;
      pulse_start();
      @(negedge clk);
      nVec++;
      if (erro !== 1'b1 || num_tentativas !== 4'd1 || ocupado !== 1'b0) begin
         nErr++;
         $display("FAIL illegal: got erro=%0b n=%0d oc=%0b, expected 1 1 0", erro, num_tentativas, ocupado);
      end
      forceMode = 0;
   endtask

   task automatic test_reset_mid();
      senhaA = 4'd15; senhaB = 3'd7; parInvert = 1'b0; forceMode = 0;
      pulse_start();
      repeat (6) @(negedge clk);
      nVec++;
      if (modoB !== 1'b1 || ocupado !== 1'b1) begin
         nErr++;
         $display("FAIL midB reach: got modoB=%0b oc=%0b, expected 1 1", modoB, ocupado);
      end
      rst_n = 1'b0;
      #1;
      nVec++;
      if ({tentativaA, tentativaB, modoB, ocupado, concluido, erro, resultadoA, resultadoB, num_tentativas} !== '0) begin
         nErr++;
         $display("FAIL midB reset: got A=%0d B=%0d modoB=%0b oc=%0b rA=%0d n=%0d, expected all 0",
                  tentativaA, tentativaB, modoB, ocupado, resultadoA, num_tentativas);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      nVec++;
      if (ocupado !== 1'b0 || num_tentativas !== 4'd0) begin
         nErr++;
         $display("FAIL midB idle: got oc=%0b n=%0d, expected 0 0", ocupado, num_tentativas);
      end
   endtask

   task automatic test_busy_start();
      senhaA = 4'd11; senhaB = 3'd5; parInvert = 1'b0; forceMode = 0;
      @(negedge clk) iniciar = 1'b1;
      @(negedge clk);
      @(negedge clk) iniciar = 1'b0;
      nVec++;
      if (tentativaA !== 4'd11 || num_tentativas !== 4'd1 || ocupado !== 1'b1) begin
         nErr++;
         $display("FAIL busy start: got tA=%0d n=%0d oc=%0b, expected 11 1 1", tentativaA, num_tentativas, ocupado);
      end
      repeat (3) @(negedge clk);
      nVec++;
      if (concluido !== 1'b1 || num_tentativas !== 4'd4) begin
         nErr++;
         $display("FAIL busy end: got co=%0b n=%0d, expected 1 4", concluido, num_tentativas);
      end
   endtask

   task automatic test_parity();
      run_search(11, 5, 1'b1, "parity");
      parInvert = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++)
         run_search(int'($urandom_range(15, 0)), int'($urandom_range(7, 0)), 1'b0, "random");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_worst();
      test_low();
      test_inconsistent();
      test_illegal();
      test_reset_mid();
      test_busy_start();
      test_parity();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
